// File: rtl/burst_sram_scheduler.sv
// Two-requester round-robin scheduler that sequences strided bursts into one
// single-port SRAM, aborting any burst whose next address would overflow.
module burst_sram_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int STRIDE_LEN = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              req,
    input  logic [1:0]              req_wr,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*STRIDE_LEN-1:0] req_stride,
    input  logic [2*LEN_WIDTH-1:0]  req_len,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              gnt,
    output logic [1:0]              beat_ack,
    output logic [1:0]              done,
    output logic [1:0]              err,
    output logic                    sram_wren,
    output logic                    sram_rden,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wr_data,
    input  logic [DATA_WIDTH-1:0]   sram_rd_data,
    output logic                    rd_valid,
    output logic                    rd_id,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]            state_reg;
    logic [ADDR_WIDTH-1:0] addr_cur_reg;
    logic [STRIDE_LEN-1:0] stride_reg;
    logic [LEN_WIDTH-1:0]  beats_left_reg;
    logic                  wr_reg;
    logic                  id_reg;
    logic                  prio_reg;
    logic                  rd_pend_reg;
    logic                  rd_pend_id_reg;
    logic                  rd_valid_reg;
    logic                  rd_id_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    logic [ADDR_WIDTH-1:0] addr_slice   [2];
    logic [STRIDE_LEN-1:0] stride_slice [2];
    logic [LEN_WIDTH-1:0]  len_slice    [2];
    logic [DATA_WIDTH-1:0] wdata_slice  [2];

    logic                  in_burst;
    logic                  last_beat;
    logic                  carry;
    logic                  grant_any;
    logic                  grant_id;
    logic [ADDR_WIDTH:0]   addr_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign addr_slice[gi]   = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign stride_slice[gi] = req_stride[gi*STRIDE_LEN +: STRIDE_LEN];
            assign len_slice[gi]    = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign wdata_slice[gi]  = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];

            // Grant is suppressed during reset so the requester never sees a
            // gnt that the FSM did not actually latch.
            assign gnt[gi]      = rstn && (state_reg == IDLE) && grant_any && (grant_id == 1'(gi));
            assign beat_ack[gi] = in_burst && (id_reg == 1'(gi));
            assign done[gi]     = beat_ack[gi] && last_beat;
            assign err[gi]      = beat_ack[gi] && !last_beat && carry;
        end
    endgenerate

    assign in_burst  = (state_reg == BURST);
    assign last_beat = (beats_left_reg == '0);
    assign grant_any = |req;
    // With both requesting, prio_reg names the requester that did not finish last.
    assign grant_id  = (req == 2'b11) ? prio_reg : req[1];

    // One extra bit catches the wrap so it can abort the burst.
    assign addr_next = {1'b0, addr_cur_reg} + {{(ADDR_WIDTH+1-STRIDE_LEN){1'b0}}, stride_reg};
    assign carry     = addr_next[ADDR_WIDTH];

    assign sram_wren    = in_burst && wr_reg;
    assign sram_rden    = in_burst && !wr_reg;
    assign sram_addr    = in_burst ? addr_cur_reg : '0;
    assign sram_wr_data = (in_burst && wr_reg) ? wdata_slice[id_reg] : '0;

    assign rd_valid = rd_valid_reg;
    assign rd_id    = rd_id_reg;
    assign rd_data  = rd_data_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            addr_cur_reg   <= '0;
            stride_reg     <= '0;
            beats_left_reg <= '0;
            wr_reg         <= 1'b0;
            id_reg         <= 1'b0;
            prio_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        addr_cur_reg   <= addr_slice[grant_id];
                        stride_reg     <= stride_slice[grant_id];
                        beats_left_reg <= len_slice[grant_id];
                        wr_reg         <= req_wr[grant_id];
                        id_reg         <= grant_id;
                        state_reg      <= BURST;
                    end
                end
                BURST: begin
                    if (last_beat) begin
                        prio_reg  <= ~id_reg;
                        state_reg <= IDLE;
                    end else if (carry) begin
                        state_reg <= IDLE;
                    end else begin
                        addr_cur_reg   <= addr_next[ADDR_WIDTH-1:0];
                        beats_left_reg <= beats_left_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read return: SRAM data arrives the cycle after rden, then is registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_pend_reg    <= 1'b0;
            rd_pend_id_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_id_reg      <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            rd_pend_reg    <= sram_rden;
            rd_pend_id_reg <= id_reg;
            rd_valid_reg   <= rd_pend_reg;
            rd_id_reg      <= rd_pend_id_reg;
            if (rd_pend_reg) begin
                rd_data_reg <= sram_rd_data;
            end
        end
    end

endmodule
